// File: rtl/shift_unit_iter.sv
// Iterative shift unit: resolves one shift-amount bit per cycle, so every SLL/SRL/SRA
// takes the same number of cycles regardless of the amount. One request in flight.
module shift_unit_iter #(
  parameter  int N       = 32,
  localparam int SHAMT_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N-1:0]       in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N-1:0]       out_data,
  output logic               busy,
  output logic [1:0]         dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
  // in_ready is high only in IDLE; out_valid is high only in DONE and the result is
  // held stable until out_ready is seen.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam int unsigned LAST_STEP = SHAMT_W - 1;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [SHAMT_W-1:0] r_step;
  logic [SHAMT_W-1:0] r_shamt;
  logic [1:0]         r_op;
  logic               r_sign;
  logic [N-1:0]       r_val;
  logic [N-1:0]       r_out;

  logic               w_last;
  logic [SHAMT_W:0]   w_amt;
  logic signed [N:0]  w_sra;
  logic [N-1:0]       w_shifted;

  assign w_last    = (r_step == LAST_STEP[SHAMT_W-1:0]);
  assign out_data  = r_out;
  assign dbg_state = r_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        busy = 1'b1;
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Step k shifts by 2^k when bit k of the latched amount is set.
  // SRA fills from the sign captured at accept, not from the working value.
  always_comb begin
    w_amt     = r_shamt[r_step] ? ((SHAMT_W+1)'(1) << r_step) : '0;
    w_sra     = $signed({r_sign, r_val}) >>> w_amt;
    w_shifted = r_val << w_amt;
    case (r_op)
      2'b01:   w_shifted = r_val >> w_amt;
      2'b11:   w_shifted = w_sra[N-1:0];
      default: w_shifted = r_val << w_amt;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_step  <= '0;
      r_shamt <= '0;
      r_op    <= '0;
      r_sign  <= 1'b0;
      r_val   <= '0;
      r_out   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_val   <= in_data;
            r_shamt <= in_shamt;
            r_op    <= in_op;
            r_sign  <= in_data[N-1];
            r_step  <= '0;
          end
        end
        S_SHIFT: begin
          r_val  <= w_shifted;
          r_step <= r_step + 1'b1;
          if (w_last) r_out <= w_shifted;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_unit_iter.sv
// Directed bench for shift_unit_iter (N=32): reset, latency, shift boundaries,
// backpressure, reserved opcode and a sweep of every shift amount against SV operators.
module tb_shift_unit_iter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic [4:0]  in_shamt = '0;
  logic [1:0]  in_op = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        busy;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  shift_unit_iter #(.N(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_shamt(in_shamt), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] d, input logic [4:0] s,
                                        input logic [1:0] op);
    case (op)
      2'b01:   return d >> s;
      2'b11:   return $unsigned($signed(d) >>> s);
      default: return d << s;
    endcase
  endfunction

  // Issue one request (caller guarantees IDLE), check latency, optional stall, result.
  task automatic run_op(input string tag, input logic [31:0] d, input logic [4:0] s,
                        input logic [1:0] op, input logic [31:0] exp, input int stall);
    int lat;
    logic [31:0] want;
    logic stable;
    exp_q.push_back(exp);
    in_data = d; in_shamt = s; in_op = op; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = $urandom; in_shamt = 5'($urandom); in_op = 2'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'd5);
    stable = 1'b1;
    want = out_data;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      if (!out_valid || out_data !== want || in_ready) stable = 1'b0;
    end
    if (stall > 0) chk({tag, "_stall"}, {31'd0, stable}, 32'd1);
    chk(tag, out_data, exp_q.pop_front());
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_idle"}, {29'd0, out_valid, in_ready, busy}, 32'b010);
  endtask

  initial begin : main
    logic [31:0] held;
    logic ok;
    int lat;

    // reset state
    #12;
    chk("rst_ports", {28'd0, in_ready, out_valid, busy, 1'b0}, 32'b1000);
    chk("rst_data", out_data, 32'h0);
    chk("rst_state", {30'd0, dbg_state}, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // boundaries and directed vectors
    run_op("sll_1_31",   32'h0000_0001, 5'd31, 2'b00, 32'h8000_0000, 0);
    run_op("sra_f0_4",   32'hF000_0000, 5'd4,  2'b11, 32'hFF00_0000, 0);
    run_op("srl_f0_4",   32'hF000_0000, 5'd4,  2'b01, 32'h0F00_0000, 2);
    run_op("sra_70_31",  32'h7000_0000, 5'd31, 2'b11, 32'h0000_0000, 0);
    run_op("srl_80_31",  32'h8000_0000, 5'd31, 2'b01, 32'h0000_0001, 0);
    run_op("sra_80_31",  32'h8000_0001, 5'd31, 2'b11, 32'hFFFF_FFFF, 1);
    run_op("rsv_sh0",    32'h1234_5678, 5'd0,  2'b10, 32'h1234_5678, 0);
    run_op("rsv_sh4",    32'h0000_000F, 5'd4,  2'b10, 32'h0000_00F0, 0);
    run_op("sll_de_4",   32'hDEAD_BEEF, 5'd4,  2'b00, 32'hEADB_EEF0, 0);
    run_op("srl_de_8",   32'hDEAD_BEEF, 5'd8,  2'b01, 32'h00DE_ADBE, 0);
    run_op("sra_de_8",   32'hDEAD_BEEF, 5'd8,  2'b11, 32'hFFDE_ADBE, 3);
    run_op("sra_sh0",    32'h8000_0000, 5'd0,  2'b11, 32'h8000_0000, 0);
    run_op("sll_3_30",   32'h0000_0003, 5'd30, 2'b00, 32'hC000_0000, 0);
    repeat (3) @(posedge clk);
    #1 chk("idle_hold", out_data, 32'hC000_0000);

    // backpressure: result held, new requests ignored while DONE
    in_data = 32'hA000_0000; in_shamt = 5'd1; in_op = 2'b01; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp_lat", 32'(lat), 32'd5);
    chk("bp_data", out_data, 32'h5000_0000);
    held = out_data;
    in_valid = 1'b1; in_data = 32'hFFFF_FFFF; in_shamt = 5'd3; in_op = 2'b00;
    ok = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (!out_valid || out_data !== held || in_ready || !busy) ok = 1'b0;
    end
    chk("bp_stable", {31'd0, ok}, 32'd1);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_release", {30'd0, in_ready, out_valid}, 32'b10);
    run_op("bp_next", 32'h0000_00FF, 5'd8, 2'b00, 32'h0000_FF00, 0);

    // out_ready held high while idle/shifting has no effect
    out_ready = 1'b1;
    in_data = 32'h0000_0010; in_shamt = 5'd2; in_op = 2'b01; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("rdy_hi_lat", 32'(lat), 32'd5);
    chk("rdy_hi_data", out_data, 32'h0000_0004);
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("rdy_hi_idle", {31'd0, in_ready}, 32'd1);

    // asynchronous reset in the middle of SHIFT
    in_data = 32'h0000_0001; in_shamt = 5'd5; in_op = 2'b00; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #3;
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_ports", {29'd0, in_ready, out_valid, busy}, 32'b100);
    chk("mid_rst_data", out_data, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    ok = 1'b1;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid || !in_ready) ok = 1'b0;
    end
    chk("post_rst_quiet", {31'd0, ok}, 32'd1);

    // every shift amount and op against the language shift operators
    for (int s = 0; s < 32; s++) begin
      logic [31:0] d;
      d = (s % 2 == 0) ? 32'h9AC3_5E17 ^ 32'(s * 32'h0101_0101) : 32'h6B2D_F048 + 32'(s);
      run_op($sformatf("sll_s%0d", s), d, 5'(s), 2'b00, model(d, 5'(s), 2'b00),
             $urandom_range(0, 2));
      run_op($sformatf("srl_s%0d", s), d, 5'(s), 2'b01, model(d, 5'(s), 2'b01),
             $urandom_range(0, 2));
      run_op($sformatf("sra_s%0d", s), d, 5'(s), 2'b11, model(d, 5'(s), 2'b11),
             $urandom_range(0, 2));
    end

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
